// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider dispatch front-end
package div_pkg;

    localparam int DIV_W = 32;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIV_W-1:0] num;
        logic [DIV_W-1:0] den;
        logic [TAG_W-1:0] tag;
    } div_req_t;

    // Done is expected 2*w+1 edges after Start; allow a few cycles of slack.
    function automatic int timeout_cycles(input int w);
        return 2 * w + 8;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - synchronous request FIFO with combinational head read
module div_req_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RSTa,
    input  logic                         push,
    input  div_req_t                     wdata,
    input  logic                         pop,
    output div_req_t                     rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    div_req_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are only meaningful when non-empty.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/div_dispatch.sv
// rtl/div_dispatch.sv - queues signed division requests and sequences the divider
module div_dispatch
    import div_pkg::*;
#(
    parameter int tamanyo = DIV_W,
    parameter int DEPTH   = 4,
    parameter int TAGW    = TAG_W
) (
    input  logic                        CLK,
    input  logic                        RSTa,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [tamanyo-1:0]          in_num,
    input  logic [tamanyo-1:0]          in_den,
    input  logic [TAGW-1:0]             in_tag,
    output logic                        div_start,
    output logic [tamanyo-1:0]          div_num,
    output logic [tamanyo-1:0]          div_den,
    input  logic [tamanyo-1:0]          div_coc,
    input  logic [tamanyo-1:0]          div_res,
    input  logic                        div_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [tamanyo-1:0]          out_coc,
    output logic [tamanyo-1:0]          out_res,
    output logic [TAGW-1:0]             out_tag,
    output logic                        out_dz,
    output logic                        out_to,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    localparam int TIMEOUT = timeout_cycles(tamanyo);
    localparam int TW      = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic                div_start_q, div_start_d;
    logic [tamanyo-1:0]  div_num_q, div_num_d;
    logic [tamanyo-1:0]  div_den_q, div_den_d;
    logic [TAGW-1:0]     tag_q, tag_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                out_valid_q, out_valid_d;
    logic [tamanyo-1:0]  out_coc_q, out_coc_d;
    logic [tamanyo-1:0]  out_res_q, out_res_d;
    logic [TAGW-1:0]     out_tag_q, out_tag_d;
    logic                out_dz_q, out_dz_d;
    logic                out_to_q, out_to_d;

    div_req_t            head, wreq;
    logic                fifo_full, fifo_empty, pop, slot_free;

    assign wreq = '{num: in_num, den: in_den, tag: in_tag};

    div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .push  (in_valid && in_ready),
        .wdata (wreq),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        div_start_d = 1'b0;
        div_num_d   = div_num_q;
        div_den_d   = div_den_q;
        tag_d       = tag_q;
        tmo_d       = tmo_q;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_coc_d   = out_coc_q;
        out_res_d   = out_res_q;
        out_tag_d   = out_tag_q;
        out_dz_d    = out_dz_q;
        out_to_d    = out_to_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_coc_d   = '0;
            out_res_d   = '0;
            out_tag_d   = '0;
            out_dz_d    = 1'b0;
            out_to_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    pop = 1'b1;
                    if (head.den == '0) begin
                        // Divide-by-zero never reaches the divider.
                        out_valid_d = 1'b1;
                        out_coc_d   = '1;
                        out_res_d   = head.num;
                        out_tag_d   = head.tag;
                        out_dz_d    = 1'b1;
                        out_to_d    = 1'b0;
                    end else begin
                        div_num_d   = head.num;
                        div_den_d   = head.den;
                        tag_d       = head.tag;
                        div_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (div_done) begin
                    out_valid_d = 1'b1;
                    out_coc_d   = div_coc;
                    out_res_d   = div_res;
                    out_tag_d   = tag_q;
                    out_dz_d    = 1'b0;
                    out_to_d    = 1'b0;
                    state_d     = IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    out_valid_d = 1'b1;
                    out_coc_d   = '0;
                    out_res_d   = '0;
                    out_tag_d   = tag_q;
                    out_dz_d    = 1'b0;
                    out_to_d    = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state_q     <= IDLE;
            div_start_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            tag_q       <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_coc_q   <= '0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_dz_q    <= 1'b0;
            out_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_start_q <= div_start_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            tag_q       <= tag_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_coc_q   <= out_coc_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
            out_dz_q    <= out_dz_d;
            out_to_q    <= out_to_d;
        end
    end

    assign div_start = div_start_q;
    assign div_num   = div_num_q;
    assign div_den   = div_den_q;
    assign out_valid = out_valid_q;
    assign out_coc   = out_coc_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
    assign out_dz    = out_dz_q;
    assign out_to    = out_to_q;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_div_dispatch.sv
// tb/tb_div_dispatch.sv - scoreboard bench for div_dispatch with a behavioural divider
module tb_div_dispatch;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    logic               CLK = 1'b0;
    logic               RSTa = 1'b1;
    logic               in_valid, in_ready;
    logic [W-1:0]       in_num, in_den;
    logic [TAGW-1:0]    in_tag;
    logic               div_start;
    logic [W-1:0]       div_num, div_den, div_coc, div_res;
    logic               div_done;
    logic               out_valid, out_ready;
    logic [W-1:0]       out_coc, out_res;
    logic [TAGW-1:0]    out_tag;
    logic               out_dz, out_to, busy;
    logic [2:0]         fifo_count;

    always #5 CLK = ~CLK;

    div_dispatch #(.tamanyo(W), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_coc(out_coc), .out_res(out_res), .out_tag(out_tag),
        .out_dz(out_dz), .out_to(out_to),
        .busy(busy), .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic [W-1:0]    coc;
        logic [W-1:0]    res;
        logic [TAGW-1:0] tag;
        logic            dz;
        logic            to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Divider: Start sampled at edge S, Done sampled by the dispatcher at S+2W+1.
    // In late mode Done comes one edge after the dispatcher has timed out.
    logic [W-1:0] m_num, m_den;
    int           m_cnt;
    int           start_cnt = 0;
    logic         late_mode = 1'b0;

    always @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            div_done <= 1'b0;
            div_coc  <= '0;
            div_res  <= '0;
            m_cnt    <= 0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                start_cnt <= start_cnt + 1;
                m_num     <= div_num;
                m_den     <= div_den;
                m_cnt     <= late_mode ? 72 : 2 * W;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    div_done <= 1'b1;
                    if (m_den == '0) begin
                        div_coc <= '1;
                        div_res <= m_num;
                    end else begin
                        div_coc <= $signed(m_num) / $signed(m_den);
                        div_res <= $signed(m_num) % $signed(m_den);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RSTa && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_tag=%0h required=none", out_tag);
            end else begin
                e = sb.pop_front();
                chk("out_coc", out_coc, e.coc);
                chk("out_res", out_res, e.res);
                chk("out_tag", out_tag, e.tag);
                chk("out_dz",  out_dz,  e.dz);
                chk("out_to",  out_to,  e.to);
            end
        end
    end

    task automatic set_req(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TAGW-1:0] t);
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        in_tag   = t;
    endtask

    task automatic finish_push(input exp_t e);
        bool_wait: for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (in_ready) break;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=in_ready0 required=in_ready1");
        end
        @(posedge CLK);
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic push_req(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TAGW-1:0] t,
                            input logic [W-1:0] ec, input logic [W-1:0] er, input logic edz, input logic eto);
        set_req(n, d, t);
        finish_push('{coc: ec, res: er, tag: t, dz: edz, to: eto});
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            k++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat, s0, nbusy;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready",   in_ready, 1);
        chk("rst_out_valid",  out_valid, 0);
        chk("rst_div_start",  div_start, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy",       busy, 0);
        chk("rst_div_num",    div_num, 0);
        @(negedge CLK);
        RSTa = 1'b0;
        @(posedge CLK);
        #1;

        s0 = start_cnt;
        push_req(32'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0);
        wait_valid(lat);
        chk("latency_100_7", lat, 68);
        drain();
        chk("start_pulses_100_7", start_cnt - s0, 1);

        push_req(32'hFFFF_FF9C, 32'd7, 4'd4, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        push_req(32'd100, 32'hFFFF_FFF9, 4'd5, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        drain();

        s0 = start_cnt;
        push_req(32'd55, 32'd0, 4'd9, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0);
        wait_valid(lat);
        chk("latency_dz", lat, 2);
        drain();
        chk("start_pulses_dz", start_cnt - s0, 0);

        out_ready = 1'b0;
        push_req(32'd20,        32'd3,         4'd1, 32'd6,         32'd2,         1'b0, 1'b0);
        push_req(32'd7,         32'd7,         4'd2, 32'd1,         32'd0,         1'b0, 1'b0);
        push_req(32'hFFFF_FFF7, 32'd2,         4'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 1'b0);
        push_req(32'd0,         32'd5,         4'd4, 32'd0,         32'd0,         1'b0, 1'b0);
        push_req(32'd1000,      32'hFFFF_FFF6, 4'd5, 32'hFFFF_FF9C, 32'd0,         1'b0, 1'b0);
        set_req(32'd13, 32'd4, 4'd6);
        repeat (80) @(negedge CLK);
        chk("full_in_ready",    in_ready, 0);
        chk("full_fifo_count",  fifo_count, 4);
        chk("full_out_valid",   out_valid, 1);
        chk("full_held_tag",    out_tag, 1);
        @(posedge CLK);
        #1 out_ready = 1'b1;
        finish_push('{coc: 32'd3, res: 32'd1, tag: 4'd6, dz: 1'b0, to: 1'b0});
        drain();

        s0 = start_cnt;
        late_mode = 1'b1;
        push_req(32'd50, 32'd5, 4'd10, 32'd0, 32'd0, 1'b0, 1'b1);
        push_req(32'd17, 32'd5, 4'd11, 32'd3, 32'd2, 1'b0, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (start_cnt != s0) late_mode = 1'b0;
            if (out_valid) break;
            if (busy) nbusy++;
        end
        chk("timeout_busy_cycles", nbusy, 73);
        chk("timeout_flag", out_to, 1);
        drain();
        chk("start_pulses_timeout", start_cnt - s0, 2);
        chk("after_timeout_idle", out_valid, 0);

        push_req(32'd1, 32'd1, 4'd12, 32'd1, 32'd0, 1'b0, 1'b0);
        push_req(32'd2, 32'd1, 4'd13, 32'd2, 32'd0, 1'b0, 1'b0);
        push_req(32'd3, 32'd1, 4'd14, 32'd3, 32'd0, 1'b0, 1'b0);
        push_req(32'd4, 32'd1, 4'd15, 32'd4, 32'd0, 1'b0, 1'b0);
        repeat (20) @(negedge CLK);
        chk("pre_rst_fifo_count", fifo_count, 3);
        chk("pre_rst_busy", busy, 1);
        #2 RSTa = 1'b1;
        #1;
        chk("mid_rst_fifo_count", fifo_count, 0);
        chk("mid_rst_out_valid",  out_valid, 0);
        chk("mid_rst_busy",       busy, 0);
        chk("mid_rst_in_ready",   in_ready, 1);
        sb.delete();
        repeat (2) @(negedge CLK);
        RSTa = 1'b0;
        @(posedge CLK);
        #1;
        push_req(32'd9, 32'd2, 4'd7, 32'd4, 32'd1, 1'b0, 1'b0);
        drain();
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_dispatch.md
# div_dispatch

Request front-end for the algorithmic divider. It accepts tagged signed operand pairs over a valid/ready handshake and buffers them in a small FIFO. It issues one division at a time to the divider through its Start/Num/Den/Coc/Res/Done port set, and returns each result, in order, over a valid/ready output with tag and status flags. It handles divide-by-zero without using the divider and recovers from a divider that never signals Done.

## Interface
- tamanyo, 32, operand/result width (matches divider parameter)
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- TAGW, 4, request tag width
- CLK  in  1  clock, rising edge
- RSTa  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  request handshake
- in_num, in_den  in  tamanyo  signed two's-complement operands
- in_tag  in  TAGW  opaque request tag
- div_start  out  1  one-cycle Start pulse to divider
- div_num, div_den  out  tamanyo  operands to divider, registered
- div_coc, div_res  in  tamanyo  divider quotient/remainder
- div_done  in  1  divider Done pulse
- out_valid / out_ready  out / in  1  result handshake
- out_coc, out_res  out  tamanyo  quotient/remainder
- out_tag  out  TAGW  tag of the request
- out_dz  out  1  divide-by-zero flag
- out_to  out  1  timeout flag
- busy  out  1  high in ISSUE or WAIT
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Reset: FIFO empty, state IDLE, every registered output 0. in_ready is 1 while FIFO is empty, including during reset.
- Push on in_valid&&in_ready. in_ready = fifo_count<DEPTH. When full, a simultaneous pop does not open in_ready that cycle.
- Output slot is free when !out_valid || out_ready.
- FSM states:
  - IDLE: if FIFO non-empty and output slot free, pop the head entry.
    - den==0: load the output register directly with out_coc='1, out_res=num, out_dz=1, out_valid=1. Stay in IDLE.
    - else: register div_num/div_den/tag, set div_start=1, go to ISSUE.
  - ISSUE: div_start=0, clear timeout counter, go to WAIT.
  - WAIT: increment timeout counter.
    - On div_done: capture div_coc/div_res into the output register, out_dz=0, out_to=0, out_valid=1, go to IDLE.
    - If the counter reaches TIMEOUT=2*tamanyo+8 first: out_coc=0, out_res=0, out_to=1, out_valid=1, go to IDLE.
  - Unreachable encodings go to IDLE.
- A div_done seen outside WAIT is ignored.
- div_num/div_den stay stable from the start pulse until leaving WAIT.
- The output register holds while out_valid&&!out_ready. It clears on handshake unless reloaded in the same cycle.
- Results leave in FIFO order. Only one division is outstanding at a time.
- Signed arithmetic is done entirely by the divider. The dispatcher passes values through bit-exact.

## Timing
- Divider contract: Start is sampled on the edge after div_start rises. Done pulses 2*tamanyo+1 edges later and lasts one cycle. Coc/Res are valid with Done and held afterwards.
- Latency with the pipe empty and out_ready=1, push edge to out_valid: 2*tamanyo+4 cycles (68 for tamanyo=32).
- Divide-by-zero latency, push edge to out_valid: 2 cycles.
- Back-to-back issue: the next pop can happen in the cycle the previous result handshakes.
- Reset mid-operation: FIFO is flushed, FSM goes to IDLE, and out_valid drops immediately (asynchronous). The integration level resets the divider in the same event, driving its active-low port with the inverted RSTa.

## Structure
- Package div_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT}
  - localparam function timeout_cycles(tamanyo)
  - struct div_req_t {num, den, tag}
- Sub-module div_req_fifo is a synchronous FIFO of div_req_t.
  - Ports: push/pop/full/empty/count, with the same CLK/RSTa.
  - Read data is combinational from the head entry.
- The top level contains the FSM, timeout counter, and output register.

## Test plan
- 100/7, tag 3 → out_coc=14, out_res=2, out_tag=3, dz=0, to=0; out_valid 68 cycles after push; exactly one div_start pulse.
- −100/7 → out_coc=0xFFFFFFF2, out_res=0xFFFFFFFE; 100/−7 → coc=0xFFFFFFF2, res=2.
- 55/0, tag 9 → out_dz=1, out_coc=0xFFFFFFFF, out_res=55, tag 9 two cycles after push; div_start never asserted.
- out_ready=0, six requests pushed back to back: first is issued, four fill the FIFO, and in_ready=0 for the sixth until a pop. Then raise out_ready: all six return in order with correct tags.
- Divider model suppresses Done → out_to=1 after 72 WAIT cycles. The next queued request then completes normally, and a late Done is ignored.
- Assert RSTa during WAIT with 3 entries queued → fifo_count=0, out_valid=0, busy=0 immediately. A fresh 9/2 request after release returns coc=4, res=1.
